eth_rx_deframer: RTL and testbench
==================================

Name: eth_rx_deframer

Overview:
- Receive-side counterpart of the frame generator; consumes the raw RMII-style dibit stream, including preamble, SFD, header, payload and FCS.
- Detects preamble and SFD, assembles bytes LSB-dibit first, strips the 14-byte header and latches EtherType.
- Withholds the trailing 4 FCS bytes and emits payload bytes only.
- Checks CRC-32 and length at end of frame, reporting through a done/err pulse. Sits between the PHY dibit capture and the payload consumer.

Parameters:
MAX_FRAME_BYTES, 1522, max bytes after SFD (header+payload+FCS); exceeding it is an error
MAC_ADDR, 48'h02_00_00_00_00_01, local MAC, first transmitted byte in bits [47:40]; used only with filter feature

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
inclk  input  1  carrier/data valid; high for every dibit of a frame, low between frames
in  input  2  received dibit, bit0 earliest on wire
outclk  output  1  one-cycle strobe, out holds a payload byte
out  output  8  payload byte
ethertype  output  16  EtherType of current frame, first received byte in [15:8]
done  output  1  one-cycle pulse, end of an accepted frame
err  output  1  valid only when done=1; frame bad (CRC, alignment, length)

Behaviour:
- Reset (rst=1 at a posedge): state IDLE; outclk=0, out=0, done=0, err=0, ethertype=0; byte buffer cleared. rst mid-frame aborts it with no done.
- States: IDLE, PREAMBLE, BODY, DROP.
- IDLE: inclk=1 and in=01 goes to PREAMBLE. inclk=1 with any other dibit goes to DROP.
- PREAMBLE: in=01 stays. in=11 (SFD) goes to BODY; the CRC register is initialised to 0xFFFFFFFF and the byte/dibit counters are cleared. Any other dibit goes to DROP. inclk=0 goes to IDLE silently (no done).
- BODY, inclk=1:
  - Each dibit is fed to the CRC (reflected poly 0xEDB88320, dibit step) and shifted into the byte assembler as bits [1:0] first.
  - Every 4th dibit completes a byte; byte_cnt increments.
  - Bytes 12,13 load ethertype high then low.
  - Bytes index ≥14 enter a 4-deep byte FIFO/delay line. When byte k+4 (k≥14) completes, byte k is emitted: outclk=1 and out=byte k on the following cycle.
  - Hence the last 4 received bytes (FCS) are never emitted.
- BODY, byte_cnt reaching MAX_FRAME_BYTES with a further byte completing: go to DROP with err_pending set; payload output stops.
- End of frame: inclk falls while in BODY, or in DROP with err_pending. On the next cycle done=1 and err=1 if any of:
  - dibit phase ≠0 (partial byte);
  - byte_cnt <18;
  - inverted CRC ≠ 32'h2144DF1C (residue, i.e. register ≠ 0xDEBB20E3);
  - err_pending.
  Otherwise done=1 with err=0. State returns to IDLE.
- DROP without err_pending: wait for inclk=0, then IDLE, no done.
- Simultaneous events:
  - A new frame starting on the cycle done pulses is accepted (state already IDLE).
  - An outclk from the final byte completion and the done pulse never coincide, because done is at least 1 cycle after the last dibit.
- Output bytes from a frame later flagged err are not retracted; the consumer discards them on err.
- ethertype holds until overwritten by byte 12 of the next frame.
- Latency: outclk is 1 cycle after the posedge sampling the completing dibit of byte k+4. done is 1 cycle after the first inclk=0 sample.

Optional Feature:
ETH_RX_MAC_FILTER_EN
- Defined: after byte 5, destination MAC is compared against MAC_ADDR and 48'hFFFFFFFFFFFF. On mismatch go to DROP without err_pending: no payload, no done.
- Undefined: all frames are accepted; MAC_ADDR is unused.

Decomposition:
- networking.vh: ETH_MAC_LEN, ETH_ETHERTYPE_LEN, ETH_CRC_LEN, ETH_PREAMBLE_LEN; add ETH_HDR_LEN=14, ETH_MIN_RX_BYTES=18, ETH_CRC_RESIDUE=32'h2144DF1C.
- Reuse existing crc32 as a submodule: rst driven by rst or SFD; shift tied 0.
- One new sub-module, byte_delay4: a 4-deep byte shift register with a valid count.

Test Plan:
- 7×01, 11, then dst FF×6, src 02 00 00 00 00 02, type 08 00, payload 01..2E (46 B), correct FCS -> 46 outclk with out=01..2E in order; ethertype=16'h0800; done=1, err=0.
- Same frame with payload byte 10 bit-flipped -> 46 outclk, done=1, err=1.
- Frame with inclk dropped 2 dibits into a byte (odd length) -> done=1, err=1.
- Preamble 01,01,00 then noise until inclk=0 -> no outclk, no done; next valid frame received correctly.
- rst pulsed after 20 body bytes, then a valid frame -> no done for the aborted frame; second frame done=1, err=0.
- With ETH_RX_MAC_FILTER_EN, dst 02:00:00:00:00:09 -> no outclk, no done; dst=MAC_ADDR -> accepted, err=0.

Source files
------------

// File: rtl/eth_rx_deframer_pkg.sv
// Shared constants, state encoding and the dibit-step CRC-32 for the RX deframer.
// Pure declarations; no logic of its own.
package eth_rx_deframer_pkg;

    localparam int ETH_MAC_LEN       = 6;
    localparam int ETH_ETHERTYPE_LEN = 2;
    localparam int ETH_CRC_LEN       = 4;
    localparam int ETH_PREAMBLE_LEN  = 7;

    localparam logic [15:0] ETH_HDR_LEN       = 16'd14;
    localparam logic [15:0] ETH_MIN_RX_BYTES  = 16'd18;
    localparam logic [15:0] ETH_ETYPE_HI_IDX  = 16'd12;
    localparam logic [15:0] ETH_ETYPE_LO_IDX  = 16'd13;
    localparam logic [15:0] ETH_DST_LAST_IDX  = 16'd5;

    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'h2144_DF1C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_BODY,
        ST_DROP
    } rx_state_e;

    // Reflected CRC-32, two bits per call, bit0 of the dibit is the earlier wire bit.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ ETH_CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_deframer_byte_delay4.sv
// 4-deep byte delay line; once full, each push pops the byte pushed four pushes earlier.
// Pop is combinational with push; no backpressure.
module eth_rx_deframer_byte_delay4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [7:0] dat_i,
    output logic       pop_vld_o,
    output logic [7:0] pop_dat_o
);

    logic [7:0] mem_q [4];
    logic [2:0] cnt_q;

    assign pop_vld_o = push_i && (cnt_q == 3'd4);
    assign pop_dat_o = mem_q[3];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
        end else if (push_i) begin
            mem_q[0] <= dat_i;
            for (int i = 1; i < 4; i++) mem_q[i] <= mem_q[i-1];
            if (cnt_q != 3'd4) cnt_q <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/eth_rx_deframer.sv
// RMII dibit deframer: strips preamble/header/FCS, emits payload, checks CRC and length.
// outclk 1 cycle after byte k+4 completes, done 1 cycle after inclk falls; no backpressure. Option: ETH_RX_MAC_FILTER_EN.
module eth_rx_deframer
    import eth_rx_deframer_pkg::*;
#(
    parameter int          MAX_FRAME_BYTES = 1522,
    parameter logic [47:0] MAC_ADDR        = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inclk,
    input  logic [1:0]  in,
    output logic        outclk,
    output logic [7:0]  out,
    output logic [15:0] ethertype,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_FRAME_BYTES);

    rx_state_e   state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [5:0]  asm_q, asm_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] etype_q, etype_d;
    logic        err_pend_q, err_pend_d;
    logic        outclk_q, outclk_d;
    logic [7:0]  out_q, out_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef ETH_RX_MAC_FILTER_EN
    logic [39:0] dst_q, dst_d;
`endif

    logic [7:0]  byte_val;
    logic        push;
    logic        clr;
    logic        pop_vld;
    logic [7:0]  pop_dat;

    eth_rx_deframer_byte_delay4 u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .push_i    (push),
        .dat_i     (byte_val),
        .pop_vld_o (pop_vld),
        .pop_dat_o (pop_dat)
    );

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        asm_d      = asm_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        etype_d    = etype_q;
        err_pend_d = err_pend_q;
        outclk_d   = 1'b0;
        out_d      = out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        push       = 1'b0;
        clr        = 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
        dst_d      = dst_q;
`endif
        byte_val   = {in, asm_q};

        case (state_q)
            ST_IDLE: begin
                err_pend_d = 1'b0;
                if (inclk) state_d = (in == 2'b01) ? ST_PREAMBLE : ST_DROP;
            end
            ST_PREAMBLE: begin
                if (!inclk) begin
                    state_d = ST_IDLE;
                end else if (in == 2'b11) begin
                    state_d    = ST_BODY;
                    crc_d      = ETH_CRC_INIT;
                    asm_d      = 6'd0;
                    phase_d    = 2'd0;
                    byte_cnt_d = 16'd0;
                    clr        = 1'b1;
                end else if (in != 2'b01) begin
                    state_d = ST_DROP;
                end
            end
            ST_BODY: begin
                if (!inclk) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = (phase_q != 2'd0) || (byte_cnt_q < ETH_MIN_RX_BYTES) ||
                              (~crc_q != ETH_CRC_RESIDUE);
                end else begin
                    crc_d   = crc32_dibit(crc_q, in);
                    asm_d   = byte_val[7:2];
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (byte_cnt_q == MAX_CNT) begin
                            state_d    = ST_DROP;
                            err_pend_d = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 16'd1;
                            if (byte_cnt_q == ETH_ETYPE_HI_IDX) etype_d[15:8] = byte_val;
                            if (byte_cnt_q == ETH_ETYPE_LO_IDX) etype_d[7:0]  = byte_val;
                            if (byte_cnt_q >= ETH_HDR_LEN) push = 1'b1;
`ifdef ETH_RX_MAC_FILTER_EN
                            if (byte_cnt_q < ETH_DST_LAST_IDX) dst_d = {dst_q[31:0], byte_val};
                            if ((byte_cnt_q == ETH_DST_LAST_IDX) &&
                                ({dst_q, byte_val} != MAC_ADDR) &&
                                ({dst_q, byte_val} != 48'hFFFF_FFFF_FFFF)) begin
                                state_d = ST_DROP;
                            end
`endif
                        end
                    end
                end
            end
            ST_DROP: begin
                // Only an overlength frame reports; silent drops just wait out the carrier.
                if (!inclk) begin
                    state_d    = ST_IDLE;
                    done_d     = err_pend_q;
                    err_d      = err_pend_q;
                    err_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop_vld) begin
            outclk_d = 1'b1;
            out_d    = pop_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            crc_q      <= ETH_CRC_INIT;
            asm_q      <= 6'd0;
            phase_q    <= 2'd0;
            byte_cnt_q <= 16'd0;
            etype_q    <= 16'd0;
            err_pend_q <= 1'b0;
            outclk_q   <= 1'b0;
            out_q      <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
            dst_q      <= 40'd0;
`endif
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            asm_q      <= asm_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            etype_q    <= etype_d;
            err_pend_q <= err_pend_d;
            outclk_q   <= outclk_d;
            out_q      <= out_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef ETH_RX_MAC_FILTER_EN
            dst_q      <= dst_d;
`endif
        end
    end

    assign outclk    = outclk_q;
    assign out       = out_q;
    assign ethertype = etype_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Directed frames for eth_rx_deframer; expected payload bytes and done/err results
// are queued at stimulus time and consumed by an independent output monitor.
module tb_eth_rx_deframer;

    logic        clk = 1'b0;
    logic        rst;
    logic        inclk;
    logic [1:0]  in_d;
    logic        outclk;
    logic [7:0]  out_b;
    logic [15:0] etype;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_b [$];
    logic       exp_e [$];
    logic [7:0] tx_q  [$];
    logic [7:0] mon_b;
    logic       mon_e;

    always #5 clk = ~clk;

    eth_rx_deframer dut (
        .clk       (clk),
        .rst       (rst),
        .inclk     (inclk),
        .in        (in_d),
        .outclk    (outclk),
        .out       (out_b),
        .ethertype (etype),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Header (dst, fixed src, type), payload 01,02,..., FCS; optional single-bit flip of a payload byte after FCS.
    task automatic build(input logic [47:0] dst, input logic [15:0] ty, input int plen, input int flip);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        logic [47:0] src;
        src = 48'h02_00_00_00_00_02;
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) tx_q.push_back(src[47-8*i -: 8]);
        tx_q.push_back(ty[15:8]);
        tx_q.push_back(ty[7:0]);
        for (int i = 0; i < plen; i++) tx_q.push_back(8'(i + 1));
        c = 32'hFFFF_FFFF;
        foreach (tx_q[i]) begin
            b = tx_q[i];
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[23:16]);
        tx_q.push_back(c[31:24]);
        if (flip >= 0) tx_q[14+flip] = tx_q[14+flip] ^ 8'h01;
    endtask

    task automatic expect_pl(input int n);
        for (int i = 0; i < n; i++) exp_b.push_back(tx_q[14+i]);
    endtask

    task automatic drive(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        inclk = v;
        in_d  = d;
    endtask

    task automatic send(input int nbytes, input int extra, input int idle);
        logic [7:0] b;
        for (int i = 0; i < 7; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int n = 0; n < nbytes; n++) begin
            b = tx_q[n];
            for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
        end
        if (extra > 0) begin
            b = tx_q[nbytes];
            for (int k = 0; k < extra; k++) drive(1'b1, b[2*k +: 2]);
        end
        for (int i = 0; i < idle; i++) drive(1'b0, 2'b00);
    endtask

    always @(negedge clk) begin
        if (outclk) begin
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_outclk: got out=%0h, want no strobe", out_b);
            end else begin
                mon_b = exp_b.pop_front();
                check("payload_byte", 32'(out_b), 32'(mon_b));
            end
        end
        if (done) begin
            if (exp_e.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got err=%0b, want no done", err);
            end else begin
                mon_e = exp_e.pop_front();
                check("done_err", 32'(err), 32'(mon_e));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        inclk = 1'b0;
        in_d  = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_outclk", 32'(outclk), 32'd0);
        check("rst_out", 32'(out_b), 32'd0);
        check("rst_ethertype", 32'(etype), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Good minimum-payload frame
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 46, -1);
        expect_pl(46);
        exp_e.push_back(1'b0);
        send(64, 0, 4);
        check("etype_good", 32'(etype), 32'h0800);

        // Same frame with payload byte 10 corrupted
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 46, 9);
        expect_pl(46);
        exp_e.push_back(1'b1);
        send(64, 0, 4);

        // Carrier drops two dibits into byte 24
        build(48'hFFFF_FFFF_FFFF, 16'h88B5, 10, -1);
        expect_pl(6);
        exp_e.push_back(1'b1);
        send(24, 2, 4);
        check("etype_odd", 32'(etype), 32'h88B5);

        // Broken preamble followed by noise, then a clean frame
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b00);
        for (int i = 0; i < 10; i++) drive(1'b1, 2'(i * 3));
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00);
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 46, -1);
        expect_pl(46);
        exp_e.push_back(1'b0);
        send(64, 0, 4);

        // Reset after 20 body bytes, then a clean frame
        build(48'hFFFF_FFFF_FFFF, 16'h0806, 46, -1);
        expect_pl(2);
        send(20, 0, 0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        inclk = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("etype_after_rst", 32'(etype), 32'd0);
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 46, -1);
        expect_pl(46);
        exp_e.push_back(1'b0);
        send(64, 0, 4);

        // Length boundary: 18 bytes accepted, 17 bytes rejected
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 0, -1);
        exp_e.push_back(1'b0);
        send(18, 0, 4);
        exp_e.push_back(1'b1);
        send(17, 0, 4);

        // Back-to-back frames separated by a single idle cycle
        build(48'hFFFF_FFFF_FFFF, 16'h0801, 20, -1);
        expect_pl(20);
        exp_e.push_back(1'b0);
        send(38, 0, 1);
        build(48'hFFFF_FFFF_FFFF, 16'h0802, 30, -1);
        expect_pl(30);
        exp_e.push_back(1'b0);
        send(48, 0, 4);
        check("etype_b2b", 32'(etype), 32'h0802);

        // Max-size frame accepted, one byte more is overlength
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 1504, -1);
        expect_pl(1504);
        exp_e.push_back(1'b0);
        send(1522, 0, 4);
        build(48'hFFFF_FFFF_FFFF, 16'h0800, 1505, -1);
        expect_pl(1504);
        exp_e.push_back(1'b1);
        send(1523, 0, 4);

`ifdef ETH_RX_MAC_FILTER_EN
        build(48'h02_00_00_00_00_09, 16'h0800, 46, -1);
        send(64, 0, 4);
        build(48'h02_00_00_00_00_01, 16'h0800, 46, -1);
        expect_pl(46);
        exp_e.push_back(1'b0);
        send(64, 0, 4);
`endif

        repeat (10) @(posedge clk);
        #1;
        check("bytes_outstanding", 32'(exp_b.size()), 32'd0);
        check("done_outstanding", 32'(exp_e.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
